// File: rtl/mem_wb_if.sv
// mem_wb_if: EX/MEM lane inputs and MEM/WB outputs of the dual-lane
// memory stage, grouped for the stage (slave) and its upstream driver (master).
interface mem_wb_if;
  logic [31:0] aluRes1_MEM;
  logic [31:0] aluRes2_MEM;
  logic [31:0] forwardBRes1_MEM;
  logic [31:0] forwardBRes2_MEM;
  logic        MemReadEn1_MEM;
  logic        MemReadEn2_MEM;
  logic        MemWriteEn1_MEM;
  logic        MemWriteEn2_MEM;
  logic        MemtoReg1_MEM;
  logic        MemtoReg2_MEM;
  logic        RegWriteEn1_MEM;
  logic        RegWriteEn2_MEM;
  logic        jal1_MEM;
  logic        jal2_MEM;
  logic [4:0]  DestReg1_MEM;
  logic [4:0]  DestReg2_MEM;
  logic [9:0]  return_addr1_MEM;
  logic [9:0]  return_addr2_MEM;

  logic        stall_mem;
  logic [31:0] aluRes1_MEM_fwd;
  logic [31:0] aluRes2_MEM_fwd;
  logic        regWrite1_WB;
  logic        regWrite2_WB;
  logic [4:0]  writeReg1_WB;
  logic [4:0]  writeReg2_WB;
  logic [31:0] writeData1_WB;
  logic [31:0] writeData2_WB;
  logic        jal1_WB;
  logic        jal2_WB;
  logic [31:0] aluRes1_WB;
  logic [31:0] aluRes2_WB;

  modport master (
    output aluRes1_MEM, aluRes2_MEM,
    output forwardBRes1_MEM, forwardBRes2_MEM,
    output MemReadEn1_MEM, MemReadEn2_MEM,
    output MemWriteEn1_MEM, MemWriteEn2_MEM,
    output MemtoReg1_MEM, MemtoReg2_MEM,
    output RegWriteEn1_MEM, RegWriteEn2_MEM,
    output jal1_MEM, jal2_MEM,
    output DestReg1_MEM, DestReg2_MEM,
    output return_addr1_MEM, return_addr2_MEM,
    input  stall_mem,
    input  aluRes1_MEM_fwd, aluRes2_MEM_fwd,
    input  regWrite1_WB, regWrite2_WB,
    input  writeReg1_WB, writeReg2_WB,
    input  writeData1_WB, writeData2_WB,
    input  jal1_WB, jal2_WB,
    input  aluRes1_WB, aluRes2_WB
  );

  modport slave (
    input  aluRes1_MEM, aluRes2_MEM,
    input  forwardBRes1_MEM, forwardBRes2_MEM,
    input  MemReadEn1_MEM, MemReadEn2_MEM,
    input  MemWriteEn1_MEM, MemWriteEn2_MEM,
    input  MemtoReg1_MEM, MemtoReg2_MEM,
    input  RegWriteEn1_MEM, RegWriteEn2_MEM,
    input  jal1_MEM, jal2_MEM,
    input  DestReg1_MEM, DestReg2_MEM,
    input  return_addr1_MEM, return_addr2_MEM,
    output stall_mem,
    output aluRes1_MEM_fwd, aluRes2_MEM_fwd,
    output regWrite1_WB, regWrite2_WB,
    output writeReg1_WB, writeReg2_WB,
    output writeData1_WB, writeData2_WB,
    output jal1_WB, jal2_WB,
    output aluRes1_WB, aluRes2_WB
  );
endinterface

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: dual-lane memory stage, single-port data RAM and MEM/WB
// register; bundles with two memory ops are serialized over two cycles.
module mem_wb_stage #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic    clk,
  input  logic    rst,
  mem_wb_if.slave bus
);

  typedef enum logic {
    IDLE,
    SECOND
  } state_t;

  state_t r_state;

  logic              w_mem1;
  logic              w_mem2;
  logic              w_both;
  logic              w_adv;
  logic              w_sel2;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_wdata;
  logic [31:0]       w_ld1;
  logic [31:0]       w_ret1;
  logic [31:0]       w_ret2;
  logic              w_unused;

  logic [31:0] r_ram [DEPTH];
  logic [31:0] r_rdata;
  logic [31:0] r_ld1;
  logic        r_ser;

  logic        r_regw1;
  logic        r_regw2;
  logic [4:0]  r_wreg1;
  logic [4:0]  r_wreg2;
  logic [31:0] r_wd1;
  logic [31:0] r_wd2;
  logic        r_m2r1;
  logic        r_m2r2;
  logic        r_jal1;
  logic        r_jal2;
  logic [31:0] r_alu1;
  logic [31:0] r_alu2;

  assign w_mem1 = bus.MemReadEn1_MEM | bus.MemWriteEn1_MEM;
  assign w_mem2 = bus.MemReadEn2_MEM | bus.MemWriteEn2_MEM;
  assign w_both = w_mem1 & w_mem2;

  // Only the first cycle of a dual-memory bundle holds the pipeline.
  assign w_adv  = ~((r_state == IDLE) & w_both);
  assign w_sel2 = (r_state == SECOND) | ~w_mem1;

  assign w_ret1 = {22'b0, bus.return_addr1_MEM};
  assign w_ret2 = {22'b0, bus.return_addr2_MEM};

  always_comb begin
    w_addr  = bus.aluRes1_MEM[ADDR_W+1:2];
    w_wdata = bus.forwardBRes1_MEM;
    w_we    = bus.MemWriteEn1_MEM;
    if (w_sel2) begin
      w_addr  = bus.aluRes2_MEM[ADDR_W+1:2];
      w_wdata = bus.forwardBRes2_MEM;
      w_we    = bus.MemWriteEn2_MEM;
    end
    w_we = w_we & rst;
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_ram[w_addr] <= w_wdata;
    end
    r_rdata <= r_ram[w_addr];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      unique case (r_state)
        IDLE:    if (w_both) r_state <= SECOND;
        SECOND:  r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Lane-1 read data arrives in SECOND and must outlive the lane-2 read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ld1 <= '0;
      r_ser <= 1'b0;
    end else begin
      r_ser <= (r_state == SECOND);
      if (r_state == SECOND) begin
        r_ld1 <= r_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_regw1 <= 1'b0;
      r_regw2 <= 1'b0;
      r_wreg1 <= '0;
      r_wreg2 <= '0;
      r_wd1   <= '0;
      r_wd2   <= '0;
      r_m2r1  <= 1'b0;
      r_m2r2  <= 1'b0;
      r_jal1  <= 1'b0;
      r_jal2  <= 1'b0;
      r_alu1  <= '0;
      r_alu2  <= '0;
    end else begin
      r_regw1 <= bus.RegWriteEn1_MEM & w_adv;
      r_regw2 <= bus.RegWriteEn2_MEM & w_adv;
      r_wreg1 <= bus.DestReg1_MEM;
      r_wreg2 <= bus.DestReg2_MEM;
      r_wd1   <= bus.jal1_MEM ? w_ret1 : bus.aluRes1_MEM;
      r_wd2   <= bus.jal2_MEM ? w_ret2 : bus.aluRes2_MEM;
      r_m2r1  <= bus.MemtoReg1_MEM & ~bus.jal1_MEM;
      r_m2r2  <= bus.MemtoReg2_MEM & ~bus.jal2_MEM;
      r_jal1  <= bus.jal1_MEM;
      r_jal2  <= bus.jal2_MEM;
      r_alu1  <= bus.aluRes1_MEM;
      r_alu2  <= bus.aluRes2_MEM;
    end
  end

  assign w_ld1 = r_ser ? r_ld1 : r_rdata;

  assign bus.stall_mem       = rst & ~w_adv;
  assign bus.aluRes1_MEM_fwd = bus.jal1_MEM ? w_ret1 : bus.aluRes1_MEM;
  assign bus.aluRes2_MEM_fwd = bus.jal2_MEM ? w_ret2 : bus.aluRes2_MEM;
  assign bus.regWrite1_WB    = r_regw1;
  assign bus.regWrite2_WB    = r_regw2;
  assign bus.writeReg1_WB    = r_wreg1;
  assign bus.writeReg2_WB    = r_wreg2;
  assign bus.writeData1_WB   = r_m2r1 ? w_ld1 : r_wd1;
  assign bus.writeData2_WB   = r_m2r2 ? r_rdata : r_wd2;
  assign bus.jal1_WB         = r_jal1;
  assign bus.jal2_WB         = r_jal2;
  assign bus.aluRes1_WB      = r_alu1;
  assign bus.aluRes2_WB      = r_alu2;

  assign w_unused = ^{bus.aluRes1_MEM[31:ADDR_W+2], bus.aluRes1_MEM[1:0],
                      bus.aluRes2_MEM[31:ADDR_W+2], bus.aluRes2_MEM[1:0]};

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed scenarios plus randomized bundles checked
// against a sequential lane-1-then-lane-2 memory model.
module tb_mem_wb_stage;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] sd;
    logic        rd;
    logic        wr;
    logic        m2r;
    logic        rw;
    logic        jal;
    logic [4:0]  dst;
    logic [9:0]  ra;
  } lane_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  logic [31:0] mdl [1024];
  bit          vld [1024];

  mem_wb_if bus ();

  mem_wb_stage #(.ADDR_W(10), .DEPTH(1024)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic lane_t mk(input logic [31:0] alu, input logic [31:0] sd,
                               input logic rd, input logic wr, input logic m2r,
                               input logic rw, input logic jal,
                               input logic [4:0] dst, input logic [9:0] ra);
    lane_t l;
    l.alu = alu; l.sd = sd; l.rd = rd; l.wr = wr; l.m2r = m2r;
    l.rw = rw; l.jal = jal; l.dst = dst; l.ra = ra;
    return l;
  endfunction

  function automatic lane_t nop();
    return mk(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 10'd0);
  endfunction

  function automatic lane_t st(input logic [31:0] a, input logic [31:0] d);
    return mk(a, d, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 10'd0);
  endfunction

  function automatic lane_t ld(input logic [31:0] a, input logic [4:0] r);
    return mk(a, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, r, 10'd0);
  endfunction

  task automatic drive(input lane_t a, input lane_t b);
    bus.aluRes1_MEM      = a.alu;  bus.aluRes2_MEM      = b.alu;
    bus.forwardBRes1_MEM = a.sd;   bus.forwardBRes2_MEM = b.sd;
    bus.MemReadEn1_MEM   = a.rd;   bus.MemReadEn2_MEM   = b.rd;
    bus.MemWriteEn1_MEM  = a.wr;   bus.MemWriteEn2_MEM  = b.wr;
    bus.MemtoReg1_MEM    = a.m2r;  bus.MemtoReg2_MEM    = b.m2r;
    bus.RegWriteEn1_MEM  = a.rw;   bus.RegWriteEn2_MEM  = b.rw;
    bus.jal1_MEM         = a.jal;  bus.jal2_MEM         = b.jal;
    bus.DestReg1_MEM     = a.dst;  bus.DestReg2_MEM     = b.dst;
    bus.return_addr1_MEM = a.ra;   bus.return_addr2_MEM = b.ra;
  endtask

  // Architectural effect of one lane: load sees all older stores.
  task automatic exec(input lane_t l, output logic [31:0] d);
    int w;
    w = int'(l.alu[11:2]);
    d = l.jal ? {22'b0, l.ra} : l.alu;
    if (l.rd && l.m2r && !l.jal) d = mdl[w];
    if (l.wr) begin
      mdl[w] = l.sd;
      vld[w] = 1'b1;
    end
  endtask

  task automatic issue(input lane_t a, input lane_t b);
    drive(a, b);
    #1;
    if ((a.rd | a.wr) && (b.rd | b.wr)) begin
      @(posedge clk); @(negedge clk);
    end
    @(posedge clk); @(negedge clk);
    drive(nop(), nop());
  endtask

  task automatic test_reset();
    drive(nop(), nop());
    #2 rst = 1'b0;
    #2;
    n_vec++;
    if ({bus.stall_mem, bus.regWrite1_WB, bus.regWrite2_WB, bus.jal1_WB,
         bus.jal2_WB} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_ctl: got %b want 0", {bus.stall_mem,
               bus.regWrite1_WB, bus.regWrite2_WB, bus.jal1_WB, bus.jal2_WB});
    end
    n_vec++;
    if ({bus.writeData1_WB, bus.writeData2_WB, bus.aluRes1_WB,
         bus.aluRes2_WB, bus.writeReg1_WB, bus.writeReg2_WB} !== '0) begin
      n_err++;
      $display("FAIL reset_data: got %h %h want 0", bus.writeData1_WB,
               bus.writeData2_WB);
    end
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_store_then_load();
    logic s0, s1;
    drive(st(32'h10, 32'hDEADBEEF), nop());
    #1 s0 = bus.stall_mem;
    @(posedge clk); @(negedge clk);
    drive(nop(), ld(32'h10, 5'd5));
    #1 s1 = bus.stall_mem;
    @(posedge clk); @(negedge clk);
    drive(nop(), nop());
    n_vec++;
    if ({s0, s1} !== 2'b00) begin
      n_err++; $display("FAIL t1_stall: got %b want 00", {s0, s1});
    end
    n_vec++;
    if ({bus.regWrite2_WB, bus.writeReg2_WB, bus.writeData2_WB} !==
        {1'b1, 5'd5, 32'hDEADBEEF}) begin
      n_err++;
      $display("FAIL t1_wb2: got %b %0d %h want 1 5 deadbeef",
               bus.regWrite2_WB, bus.writeReg2_WB, bus.writeData2_WB);
    end
  endtask

  task automatic test_serialize_st_ld();
    drive(st(32'h20, 32'h1234), ld(32'h20, 5'd7));
    #1;
    n_vec++;
    if (bus.stall_mem !== 1'b1) begin
      n_err++; $display("FAIL t2_stall: got %b want 1", bus.stall_mem);
    end
    @(posedge clk); @(negedge clk);
    n_vec++;
    if ({bus.stall_mem, bus.regWrite1_WB, bus.regWrite2_WB} !== 3'b000) begin
      n_err++;
      $display("FAIL t2_bubble: got %b want 000", {bus.stall_mem,
               bus.regWrite1_WB, bus.regWrite2_WB});
    end
    @(posedge clk); @(negedge clk);
    drive(nop(), nop());
    n_vec++;
    if ({bus.regWrite2_WB, bus.writeData2_WB} !== {1'b1, 32'h1234}) begin
      n_err++;
      $display("FAIL t2_wd2: got %b %h want 1 00001234", bus.regWrite2_WB,
               bus.writeData2_WB);
    end
  endtask

  task automatic test_dual_load();
    issue(st(32'h24, 32'h55), nop());
    drive(ld(32'h20, 5'd1), ld(32'h24, 5'd2));
    #1;
    n_vec++;
    if (bus.stall_mem !== 1'b1) begin
      n_err++; $display("FAIL t3_stall: got %b want 1", bus.stall_mem);
    end
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    drive(nop(), nop());
    n_vec++;
    if ({bus.writeData1_WB, bus.writeData2_WB} !== {32'h1234, 32'h55}) begin
      n_err++;
      $display("FAIL t3_wd: got %h %h want 00001234 00000055",
               bus.writeData1_WB, bus.writeData2_WB);
    end
  endtask

  task automatic test_jal();
    lane_t a, b;
    a = mk(32'h99, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd1, 10'h3FF);
    b = mk(32'h7, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd2, 10'h0);
    drive(a, b);
    #1;
    n_vec++;
    if ({bus.aluRes1_MEM_fwd, bus.aluRes2_MEM_fwd} !== {32'h3FF, 32'h7}) begin
      n_err++;
      $display("FAIL t4_fwd: got %h %h want 000003ff 00000007",
               bus.aluRes1_MEM_fwd, bus.aluRes2_MEM_fwd);
    end
    @(posedge clk); @(negedge clk);
    drive(nop(), nop());
    n_vec++;
    if ({bus.writeData1_WB, bus.writeData2_WB, bus.jal1_WB} !==
        {32'h3FF, 32'h7, 1'b1}) begin
      n_err++;
      $display("FAIL t4_wb: got %h %h %b want 3ff 7 1", bus.writeData1_WB,
               bus.writeData2_WB, bus.jal1_WB);
    end
  endtask

  task automatic test_store_store();
    issue(st(32'h40, 32'h1), st(32'h40, 32'h2));
    issue(ld(32'h40, 5'd3), nop());
    n_vec++;
    if (bus.writeData1_WB !== 32'h2) begin
      n_err++;
      $display("FAIL t5_ld: got %h want 00000002", bus.writeData1_WB);
    end
  endtask

  task automatic test_reset_second();
    issue(st(32'h84, 32'h5A5A), nop());
    drive(st(32'h80, 32'h111), st(32'h84, 32'h222));
    @(posedge clk); @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_vec++;
    if ({bus.stall_mem, bus.regWrite1_WB, bus.regWrite2_WB, bus.jal1_WB,
         bus.jal2_WB} !== 5'b0) begin
      n_err++; $display("FAIL t6_ctl: got %b want 0", {bus.stall_mem,
               bus.regWrite1_WB, bus.regWrite2_WB, bus.jal1_WB, bus.jal2_WB});
    end
    n_vec++;
    if ({bus.writeData1_WB, bus.writeData2_WB, bus.aluRes1_WB,
         bus.aluRes2_WB} !== '0) begin
      n_err++; $display("FAIL t6_data: got %h %h want 0",
               bus.writeData1_WB, bus.writeData2_WB);
    end
    drive(nop(), nop());
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    issue(ld(32'h80, 5'd1), ld(32'h84, 5'd2));
    n_vec++;
    if ({bus.writeData1_WB, bus.writeData2_WB} !== {32'h111, 32'h5A5A}) begin
      n_err++;
      $display("FAIL t6_mem: got %h %h want 00000111 00005a5a",
               bus.writeData1_WB, bus.writeData2_WB);
    end
  endtask

  function automatic lane_t rnd_lane();
    lane_t l;
    int op;
    logic [9:0] idx;
    l = nop();
    op = int'($urandom_range(0, 3));
    idx = 10'h100 + 10'($urandom_range(0, 7));
    l.alu = $urandom;
    l.sd = $urandom;
    l.dst = 5'($urandom);
    l.rw = 1'($urandom);
    l.ra = 10'($urandom);
    if (op == 1 && !vld[idx]) op = 2;
    case (op)
      1: begin
        l.alu = {l.alu[31:12], idx, l.alu[1:0]};
        l.rd = 1'b1; l.m2r = 1'b1;
      end
      2: begin
        l.alu = {l.alu[31:12], idx, l.alu[1:0]};
        l.wr = 1'b1; l.rw = 1'b0;
      end
      3: l.jal = 1'b1;
      default: ;
    endcase
    return l;
  endfunction

  task automatic test_random(input int n);
    for (int k = 0; k < n; k++) begin
      lane_t a, b;
      logic [31:0] e1, e2;
      logic two;
      a = rnd_lane(); exec(a, e1);
      b = rnd_lane(); exec(b, e2);
      two = (a.rd | a.wr) & (b.rd | b.wr);
      drive(a, b);
      #1;
      n_vec++;
      if (bus.stall_mem !== two) begin
        n_err++;
        $display("FAIL rnd_stall[%0d]: got %b want %b", k, bus.stall_mem, two);
      end
      if (two) begin
        @(posedge clk); @(negedge clk);
        n_vec++;
        if ({bus.stall_mem, bus.regWrite1_WB, bus.regWrite2_WB} !== 3'b0) begin
          n_err++;
          $display("FAIL rnd_bubble[%0d]: got %b want 000", k, {bus.stall_mem,
                   bus.regWrite1_WB, bus.regWrite2_WB});
        end
      end
      @(posedge clk); @(negedge clk);
      n_vec++;
      if ({bus.regWrite1_WB, bus.writeReg1_WB, bus.writeData1_WB,
           bus.jal1_WB, bus.aluRes1_WB} !== {a.rw, a.dst, e1, a.jal, a.alu}) begin
        n_err++;
        $display("FAIL rnd_l1[%0d]: got %b %0d %h %b %h want %b %0d %h %b %h",
                 k, bus.regWrite1_WB, bus.writeReg1_WB, bus.writeData1_WB,
                 bus.jal1_WB, bus.aluRes1_WB, a.rw, a.dst, e1, a.jal, a.alu);
      end
      n_vec++;
      if ({bus.regWrite2_WB, bus.writeReg2_WB, bus.writeData2_WB,
           bus.jal2_WB, bus.aluRes2_WB} !== {b.rw, b.dst, e2, b.jal, b.alu}) begin
        n_err++;
        $display("FAIL rnd_l2[%0d]: got %b %0d %h %b %h want %b %0d %h %b %h",
                 k, bus.regWrite2_WB, bus.writeReg2_WB, bus.writeData2_WB,
                 bus.jal2_WB, bus.aluRes2_WB, b.rw, b.dst, e2, b.jal, b.alu);
      end
    end
    drive(nop(), nop());
  endtask

  initial begin
    test_reset();
    test_store_then_load();
    test_serialize_st_ld();
    test_dual_load();
    test_jal();
    test_store_store();
    test_reset_second();
    test_random(300);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
